fetch_unit: RTL and testbench

Parametrised instruction fetch stage for the Pillar core, replacing the single-register PC loader. Holds the program counter, issues sequential word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small FIFO for decode. Accepts redirects (branch, jump, trap) that flush in-flight and buffered work and restart fetch at a new address.

---
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory-side and decode-side signals of the fetch stage.
//
//   mem_req_o / mem_addr_o          fetch request and word address
//   mem_gnt_i                       request accepted this cycle
//   mem_rvalid_i / mem_rdata_i      in-order read response
//   instr_valid_o / instr_o /
//   instr_pc_o / instr_ready_i      instruction buffer head toward decode
//
// Handshakes:
//   - A request transfers in any cycle where mem_req_o && mem_gnt_i.
//   - A response transfers in any cycle where mem_rvalid_i is high.
//   - An instruction transfers in any cycle where instr_valid_o && instr_ready_i.
//   Valid never waits on ready.
//
// modport master: the fetch unit.  modport slave: memory plus decode.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;
  logic            instr_valid_o;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//
// Holds the program counter and issues sequential word fetches with at most
// one request outstanding.  Returned words are buffered together with their
// PC in a FIFO for decode.  A redirect flushes the buffer, restarts fetch at
// the new target and drops the response of any request already issued.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-low reset
//   redirect_i     load redirect_pc_i as the next fetch PC, flush buffer
//   redirect_pc_i  redirect target (low two bits forced to zero)
//   pc_o           current next-fetch PC
//   state_o        fetch state (0 = REQ, 1 = WAIT, 2 = DISCARD)
//   bus            memory and decode handshakes (fetch_unit_if.master)
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [1:0]       state_o,
  fetch_unit_if.master     bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;

  logic [31:0]     data_q [FIFO_DEPTH];
  logic [XLEN-1:0] pcq_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic            credit;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  // Only one request can be outstanding, so a free FIFO slot at issue time
  // guarantees the response always has room.
  assign credit = (count < CNT_W'(FIFO_DEPTH));

  // Request is suppressed while reset is held so nothing is issued before the
  // state machine is live.
  assign bus.mem_req_o  = reset && (state == ST_REQ) && credit;
  assign bus.mem_addr_o = pc;

  assign issue  = bus.mem_req_o && bus.mem_gnt_i;
  assign push   = (state == ST_WAIT) && bus.mem_rvalid_i && !redirect_i;
  assign pop    = bus.instr_valid_o && bus.instr_ready_i && !redirect_i;
  assign target = redirect_pc_i & ~XLEN'(3);

  // Fetch state machine and program counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_REQ;
      pc     <= RESET_VECTOR;
      req_pc <= '0;
    end else if (redirect_i) begin
      pc <= target;
      case (state)
        // A request granted in the redirect cycle is already in flight; its
        // response must still be absorbed.
        ST_REQ:     state <= issue ? ST_DISCARD : ST_REQ;
        ST_WAIT:    state <= bus.mem_rvalid_i ? ST_REQ : ST_DISCARD;
        ST_DISCARD: state <= bus.mem_rvalid_i ? ST_REQ : ST_DISCARD;
        default:    state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (issue) begin
            req_pc <= pc;
            pc     <= pc + XLEN'(4);
            state  <= ST_WAIT;
          end
        end
        ST_WAIT:    if (bus.mem_rvalid_i) state <= ST_REQ;
        ST_DISCARD: if (bus.mem_rvalid_i) state <= ST_REQ;
        default:    state <= ST_REQ;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset: the head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.mem_rdata_i;
      pcq_q[wr_ptr]  <= req_pc;
    end
  end

  assign bus.instr_valid_o = (count != '0);
  assign bus.instr_o       = bus.instr_valid_o ? data_q[rd_ptr] : '0;
  assign bus.instr_pc_o    = bus.instr_valid_o ? pcq_q[rd_ptr] : '0;

  assign pc_o    = pc;
  assign state_o = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [1:0]  state_o;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .pc_o(pc_o),
    .state_o(state_o),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    redirect_i        = 1'b0;
    redirect_pc_i     = '0;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = '0;
    bus.instr_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   bus.mem_req_o,     1'b0);
    chk("rst_addr",  bus.mem_addr_o,    32'h0);
    chk("rst_iv",    bus.instr_valid_o, 1'b0);
    chk("rst_instr", bus.instr_o,       32'h0);
    chk("rst_ipc",   bus.instr_pc_o,    32'h0);
    chk("rst_pc",    pc_o,              32'h0);
    chk("rst_state", state_o,           2'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // Memory responder state for the longer sequences.
  logic        prev_gnt;
  logic [31:0] prev_addr;
  int          grants;

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Sequential fetch with pops, then redirect to 0x103 while in WAIT.
    //            redir rpc           gnt   rvalid rdata          ready  req   addr          iv    instr          ipc           pc
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1111_0000,  1'b1, 1'b0, 32'h4,        1'b0, 32'h0,         32'h0,        32'h4};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h4,        1'b1, 32'h1111_0000, 32'h0,        32'h4};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h2222_0004,  1'b1, 1'b0, 32'h8,        1'b0, 32'h0,         32'h0,        32'h8};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8,        1'b1, 32'h2222_0004, 32'h4,        32'h8};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3333_0008,  1'b1, 1'b0, 32'hC,        1'b0, 32'h0,         32'h0,        32'hC};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'hC,        1'b1, 32'h3333_0008, 32'h8,        32'hC};
    vecs[7]  = '{1'b1, 32'h103,      1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h10,       1'b1, 32'h3333_0008, 32'h8,        32'h10};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_000C,  1'b1, 1'b0, 32'h100,      1'b0, 32'h0,         32'h0,        32'h100};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h100,      1'b0, 32'h0,         32'h0,        32'h100};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h4444_0100,  1'b1, 1'b0, 32'h104,      1'b0, 32'h0,         32'h0,        32'h104};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h104,      1'b1, 32'h4444_0100, 32'h100,      32'h104};

    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      redirect_i        = vecs[i].redir;
      redirect_pc_i     = vecs[i].rpc;
      bus.mem_gnt_i     = vecs[i].gnt;
      bus.mem_rvalid_i  = vecs[i].rvalid;
      bus.mem_rdata_i   = vecs[i].rdata;
      bus.instr_ready_i = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_req", i),   bus.mem_req_o,     vecs[i].e_req);
      chk($sformatf("v%0d_addr", i),  bus.mem_addr_o,    vecs[i].e_addr);
      chk($sformatf("v%0d_iv", i),    bus.instr_valid_o, vecs[i].e_iv);
      chk($sformatf("v%0d_instr", i), bus.instr_o,       vecs[i].e_instr);
      chk($sformatf("v%0d_ipc", i),   bus.instr_pc_o,    vecs[i].e_ipc);
      chk($sformatf("v%0d_pc", i),    pc_o,              vecs[i].e_pc);
      @(negedge clk);
    end

    // ---- FIFO fills with decode stalled: exactly four fetches ----
    do_reset();
    prev_gnt  = 1'b0;
    prev_addr = '0;
    grants    = 0;
    for (int c = 0; c < 10; c++) begin
      bus.instr_ready_i = 1'b0;
      bus.mem_rvalid_i  = prev_gnt;
      bus.mem_rdata_i   = 32'hA000_0000 | prev_addr;
      bus.mem_gnt_i     = bus.mem_req_o;
      if (bus.mem_gnt_i) begin
        grants++;
        prev_addr = bus.mem_addr_o;
      end
      prev_gnt = bus.mem_gnt_i;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("full_grants", 64'(grants),        64'd4);
    chk("full_req",    bus.mem_req_o,      1'b0);
    chk("full_iv",     bus.instr_valid_o,  1'b1);
    chk("full_ipc",    bus.instr_pc_o,     32'h0);
    chk("full_instr",  bus.instr_o,        32'hA000_0000);
    chk("full_pc",     pc_o,               32'h10);
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    bus.instr_ready_i = 1'b0;
    #1;
    chk("pop_req",   bus.mem_req_o,  1'b1);
    chk("pop_addr",  bus.mem_addr_o, 32'h10);
    chk("pop_ipc",   bus.instr_pc_o, 32'h4);
    chk("pop_instr", bus.instr_o,    32'hA000_0004);

    // ---- grant withheld for five cycles: request and address held ----
    for (int c = 0; c < 5; c++) begin
      bus.mem_gnt_i = 1'b0;
      #1;
      chk($sformatf("stall%0d_req", c),  bus.mem_req_o,  1'b1);
      chk($sformatf("stall%0d_addr", c), bus.mem_addr_o, 32'h10);
      chk($sformatf("stall%0d_pc", c),   pc_o,           32'h10);
      @(negedge clk);
    end

    // ---- redirect together with grant and pop, FIFO holding 3 ----
    bus.mem_gnt_i     = 1'b1;
    bus.instr_ready_i = 1'b1;
    redirect_i        = 1'b1;
    redirect_pc_i     = 32'h200;
    #1;
    chk("rg_pre_iv",  bus.instr_valid_o, 1'b1);
    chk("rg_pre_req", bus.mem_req_o,     1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rg_iv",    bus.instr_valid_o, 1'b0);
    chk("rg_pc",    pc_o,              32'h200);
    chk("rg_req",   bus.mem_req_o,     1'b0);
    chk("rg_state", state_o,           2'd2);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0BAD_0010;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rg_drop_iv", bus.instr_valid_o, 1'b0);
    chk("rg_req2",    bus.mem_req_o,     1'b1);
    chk("rg_addr2",   bus.mem_addr_o,    32'h200);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_0200;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rg_iv2",    bus.instr_valid_o, 1'b1);
    chk("rg_ipc2",   bus.instr_pc_o,    32'h200);
    chk("rg_instr2", bus.instr_o,       32'h5555_0200);

    // ---- wrap at top of address space, then reset while in WAIT ----
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wr_req",  bus.mem_req_o,     1'b1);
    chk("wr_addr", bus.mem_addr_o,    32'hFFFF_FFFC);
    chk("wr_iv",   bus.instr_valid_o, 1'b0);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wr_pc",    pc_o,    32'h0);
    chk("wr_state", state_o, 2'd1);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h7777_FFFC;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wr_iv2",  bus.instr_valid_o, 1'b1);
    chk("wr_ipc2", bus.instr_pc_o,    32'hFFFF_FFFC);
    chk("wr_addr2", bus.mem_addr_o,   32'h0);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wt_state", state_o, 2'd1);
    chk("wt_pc",    pc_o,    32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_req",   bus.mem_req_o,     1'b0);
    chk("ar_addr",  bus.mem_addr_o,    32'h0);
    chk("ar_iv",    bus.instr_valid_o, 1'b0);
    chk("ar_instr", bus.instr_o,       32'h0);
    chk("ar_ipc",   bus.instr_pc_o,    32'h0);
    chk("ar_pc",    pc_o,              32'h0);
    chk("ar_state", state_o,           2'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_req",  bus.mem_req_o,  1'b1);
    chk("rel_addr", bus.mem_addr_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
